// File: rtl/dl_pkg.sv
// rtl/dl_pkg.sv - shared types and constants for the download controller
package dl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } dl_state_t;

    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] CFG_INDEX_DEF = 8'd1;
    localparam logic [7:0] DSW_INDEX_DEF = 8'd254;
    localparam int         DSW_BYTES     = 8;

endpackage

// File: rtl/rst_stretch.sv
// rtl/rst_stretch.sv - loadable down-counter that stretches the core reset
module rst_stretch #(
    parameter int RST_HOLD = 4800
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(RST_HOLD - 1);

    logic [CW-1:0] r_cnt;

    // Reload on demand, otherwise count down and park at zero
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= LOAD_VAL;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dl_ctrl.sv
// rtl/dl_ctrl.sv - hps_io download demux and core reset sequencer (optional DL_CHECKSUM_EN)
module dl_ctrl
    import dl_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX = ROM_INDEX_DEF,
    parameter logic [7:0] CFG_INDEX = CFG_INDEX_DEF,
    parameter logic [7:0] DSW_INDEX = DSW_INDEX_DEF,
    parameter int         RST_HOLD  = 4800
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_rst,
    output logic        rom_we,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [7:0]  sysmode,
    output logic [63:0] dsw,
    output logic        core_reset,
    output logic        dl_busy,
    output logic [7:0]  checksum
);

    dl_state_t   r_state;
    logic        r_rom_we;
    logic [24:0] r_rom_addr;
    logic [7:0]  r_rom_data;
    logic [7:0]  r_sysmode;
    logic [63:0] r_dsw;
    logic        r_core_reset;

    logic w_rom_hit;
    logic w_cfg_hit;
    logic w_dsw_hit;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign w_rom_hit  = ioctl_wr && (ioctl_index == ROM_INDEX);
    assign w_cfg_hit  = ioctl_wr && (ioctl_index == CFG_INDEX) && (ioctl_addr == 25'd0);
    assign w_dsw_hit  = ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr[24:3] == 22'd0);
    assign w_cnt_load = (r_state == LOAD) && !ioctl_download;
    assign w_cnt_dec  = (r_state == HOLD);

    rst_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_stretch (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_load  (w_cnt_load),
        .i_dec   (w_cnt_dec),
        .o_zero  (w_cnt_zero)
    );

    // Download state machine with registered core reset; a new download preempts the hold
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= HOLD;
            r_core_reset <= 1'b1;
        end else begin
            r_core_reset <= user_rst | (r_state != RUN);
            case (r_state)
                RUN:     if (ioctl_download) r_state <= LOAD;
                LOAD:    if (!ioctl_download) r_state <= HOLD;
                HOLD: begin
                    if (ioctl_download)  r_state <= LOAD;
                    else if (w_cnt_zero) r_state <= RUN;
                end
                default: r_state <= HOLD;
            endcase
        end
    end

    // Byte demux: accepted in every state; rom address/data move only on ROM writes
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_we   <= 1'b0;
            r_rom_addr <= 25'd0;
            r_rom_data <= 8'd0;
            r_sysmode  <= 8'd0;
            r_dsw      <= 64'd0;
        end else begin
            r_rom_we <= w_rom_hit;
            if (w_rom_hit) begin
                r_rom_addr <= ioctl_addr;
                r_rom_data <= ioctl_dout;
            end
            if (w_cfg_hit) r_sysmode <= ioctl_dout;
            if (w_dsw_hit) r_dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic       w_enter_load;
    logic [7:0] r_checksum;

    assign w_enter_load = (r_state != LOAD) && ioctl_download;

    // Running byte sum, restarted when a ROM download begins
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= 8'd0;
        end else if (w_enter_load && (ioctl_index == ROM_INDEX)) begin
            r_checksum <= 8'd0;
        end else if (r_rom_we) begin
            r_checksum <= r_checksum + r_rom_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'd0;
`endif

    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign sysmode    = r_sysmode;
    assign dsw        = r_dsw;
    assign core_reset = r_core_reset;
    assign dl_busy    = (r_state == LOAD);

endmodule

// File: tb/tb_dl_ctrl.sv
// tb/tb_dl_ctrl.sv - table-driven self-checking bench for dl_ctrl
`timescale 1ns/1ps
module tb_dl_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_rst;
    logic        rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  sysmode;
    logic [63:0] dsw;
    logic        core_reset;
    logic        dl_busy;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;

    always #10 clk_sys = ~clk_sys;

    dl_ctrl u_dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .user_rst       (user_rst),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .sysmode        (sysmode),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .dl_busy        (dl_busy),
        .checksum       (checksum)
    );

    typedef struct {
        logic        dl;
        logic        wr;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        e_we;
        logic [24:0] e_addr;
        logic [7:0]  e_data;
        logic [7:0]  e_sys;
        logic [63:0] e_dsw;
        logic        e_busy;
        logic [7:0]  e_cks;
    } vec_t;

    vec_t vt [19];

    function automatic logic [7:0] ck(input logic [7:0] v);
`ifdef DL_CHECKSUM_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    function automatic vec_t mk(input logic dl, input logic wr, input logic [7:0] idx,
                                input logic [24:0] addr, input logic [7:0] dout,
                                input logic e_we, input logic [24:0] e_addr, input logic [7:0] e_data,
                                input logic [7:0] e_sys, input logic [63:0] e_dsw,
                                input logic e_busy, input logic [7:0] e_cks);
        vec_t v;
        v.dl = dl; v.wr = wr; v.idx = idx; v.addr = addr; v.dout = dout;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_sys = e_sys;
        v.e_dsw = e_dsw; v.e_busy = e_busy; v.e_cks = ck(e_cks);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Counts post-edge samples with core_reset high until it drops (bounded)
    task automatic count_hold(output int n);
        n = 0;
        for (int k = 0; k < 6000; k++) begin
            step();
            if (core_reset) n++;
            else break;
        end
    endtask

    task automatic apply_vec(input int i);
        ioctl_download = vt[i].dl;
        ioctl_wr       = vt[i].wr;
        ioctl_index    = vt[i].idx;
        ioctl_addr     = vt[i].addr;
        ioctl_dout     = vt[i].dout;
        step();
        chk($sformatf("v%0d rom_we", i),   {63'd0, rom_we},   {63'd0, vt[i].e_we});
        chk($sformatf("v%0d rom_addr", i), {39'd0, rom_addr}, {39'd0, vt[i].e_addr});
        chk($sformatf("v%0d rom_data", i), {56'd0, rom_data}, {56'd0, vt[i].e_data});
        chk($sformatf("v%0d sysmode", i),  {56'd0, sysmode},  {56'd0, vt[i].e_sys});
        chk($sformatf("v%0d dsw", i),      dsw,               vt[i].e_dsw);
        chk($sformatf("v%0d dl_busy", i),  {63'd0, dl_busy},  {63'd0, vt[i].e_busy});
        chk($sformatf("v%0d checksum", i), {56'd0, checksum}, {56'd0, vt[i].e_cks});
    endtask

    initial begin
        int n;
        int bad;
        logic [63:0] d8;

        d8 = 64'hA7A6A5A4A3A2A1A0;
        //          dl    wr    idx     addr    dout    we    addr    data    sys     dsw                     busy  cks
        vt[0]  = mk(1'b1, 1'b0, 8'h00, 25'd0, 8'h00, 1'b0, 25'd0, 8'h00, 8'h00, 64'd0,                   1'b1, 8'h00);
        vt[1]  = mk(1'b1, 1'b1, 8'h00, 25'd0, 8'h12, 1'b1, 25'd0, 8'h12, 8'h00, 64'd0,                   1'b1, 8'h00);
        vt[2]  = mk(1'b1, 1'b0, 8'h00, 25'd0, 8'h00, 1'b0, 25'd0, 8'h12, 8'h00, 64'd0,                   1'b1, 8'h12);
        vt[3]  = mk(1'b1, 1'b1, 8'h00, 25'd1, 8'h34, 1'b1, 25'd1, 8'h34, 8'h00, 64'd0,                   1'b1, 8'h12);
        vt[4]  = mk(1'b1, 1'b0, 8'h00, 25'd0, 8'h00, 1'b0, 25'd1, 8'h34, 8'h00, 64'd0,                   1'b1, 8'h46);
        vt[5]  = mk(1'b1, 1'b1, 8'hFE, 25'd0, 8'hA0, 1'b0, 25'd1, 8'h34, 8'h00, 64'h00000000000000A0,    1'b1, 8'h46);
        vt[6]  = mk(1'b1, 1'b1, 8'hFE, 25'd1, 8'hA1, 1'b0, 25'd1, 8'h34, 8'h00, 64'h000000000000A1A0,    1'b1, 8'h46);
        vt[7]  = mk(1'b1, 1'b1, 8'hFE, 25'd2, 8'hA2, 1'b0, 25'd1, 8'h34, 8'h00, 64'h0000000000A2A1A0,    1'b1, 8'h46);
        vt[8]  = mk(1'b1, 1'b1, 8'hFE, 25'd3, 8'hA3, 1'b0, 25'd1, 8'h34, 8'h00, 64'h00000000A3A2A1A0,    1'b1, 8'h46);
        vt[9]  = mk(1'b1, 1'b1, 8'hFE, 25'd4, 8'hA4, 1'b0, 25'd1, 8'h34, 8'h00, 64'h000000A4A3A2A1A0,    1'b1, 8'h46);
        vt[10] = mk(1'b1, 1'b1, 8'hFE, 25'd5, 8'hA5, 1'b0, 25'd1, 8'h34, 8'h00, 64'h0000A5A4A3A2A1A0,    1'b1, 8'h46);
        vt[11] = mk(1'b1, 1'b1, 8'hFE, 25'd6, 8'hA6, 1'b0, 25'd1, 8'h34, 8'h00, 64'h00A6A5A4A3A2A1A0,    1'b1, 8'h46);
        vt[12] = mk(1'b1, 1'b1, 8'hFE, 25'd7, 8'hA7, 1'b0, 25'd1, 8'h34, 8'h00, d8,                      1'b1, 8'h46);
        vt[13] = mk(1'b1, 1'b1, 8'hFE, 25'd8, 8'hFF, 1'b0, 25'd1, 8'h34, 8'h00, d8,                      1'b1, 8'h46);
        vt[14] = mk(1'b1, 1'b1, 8'h07, 25'd0, 8'h55, 1'b0, 25'd1, 8'h34, 8'h00, d8,                      1'b1, 8'h46);
        vt[15] = mk(1'b0, 1'b1, 8'h01, 25'd0, 8'h05, 1'b0, 25'd1, 8'h34, 8'h05, d8,                      1'b0, 8'h46);
        vt[16] = mk(1'b0, 1'b1, 8'h01, 25'd1, 8'h09, 1'b0, 25'd1, 8'h34, 8'h05, d8,                      1'b0, 8'h46);
        vt[17] = mk(1'b0, 1'b1, 8'h00, 25'd2, 8'h77, 1'b1, 25'd2, 8'h77, 8'h05, d8,                      1'b0, 8'h46);
        vt[18] = mk(1'b0, 1'b0, 8'h00, 25'd0, 8'h00, 1'b0, 25'd2, 8'h77, 8'h05, d8,                      1'b0, 8'hBD);

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'h00;
        ioctl_addr = 25'd0; ioctl_dout = 8'h00; user_rst = 1'b0;
        step(); step();

        // Held-in-reset state
        chk("rst core_reset", {63'd0, core_reset}, 64'd1);
        chk("rst dl_busy",    {63'd0, dl_busy},    64'd0);
        chk("rst rom_we",     {63'd0, rom_we},     64'd0);
        chk("rst rom_addr",   {39'd0, rom_addr},   64'd0);
        chk("rst rom_data",   {56'd0, rom_data},   64'd0);
        chk("rst sysmode",    {56'd0, sysmode},    64'd0);
        chk("rst dsw",        dsw,                 64'd0);
        chk("rst checksum",   {56'd0, checksum},   64'd0);

        // Reset release, no download
        reset_n = 1'b1;
        count_hold(n);
        chk("release hold cycles", 64'(n), 64'd4800);

        // ROM download of two bytes, then the post-download hold
        for (int i = 0; i < 5; i++) apply_vec(i);
        ioctl_download = 1'b0;
        step();
        count_hold(n);
        chk("rom dl hold cycles", 64'(n), 64'd4800);

        // DIP, unmatched index, sysmode on the falling-download cycle, writes in HOLD
        for (int i = 5; i < 19; i++) apply_vec(i);

        // Re-download during HOLD around cycle 100
        ioctl_wr = 1'b0; ioctl_index = 8'h00;
        bad = 0;
        for (int k = 0; k < 96; k++) begin
            step();
            if (!core_reset || dl_busy) bad++;
        end
        chk("hold core_reset steady", 64'(bad), 64'd0);
        ioctl_download = 1'b1;
        step();
        chk("redl dl_busy",    {63'd0, dl_busy},    64'd1);
        chk("redl core_reset", {63'd0, core_reset}, 64'd1);
        chk("redl checksum",   {56'd0, checksum},   64'd0);
        step(); step();
        chk("redl core_reset held", {63'd0, core_reset}, 64'd1);
        ioctl_download = 1'b0;
        step();
        count_hold(n);
        chk("redl hold cycles", 64'(n), 64'd4800);
        chk("keep sysmode", {56'd0, sysmode}, 64'h05);
        chk("keep dsw",     dsw,              d8);

        // user_rst passes through one cycle later
        user_rst = 1'b1;
        step();
        chk("user_rst high", {63'd0, core_reset}, 64'd1);
        user_rst = 1'b0;
        step();
        chk("user_rst low", {63'd0, core_reset}, 64'd0);

        // Reset pulsed mid ROM download
        ioctl_download = 1'b1; ioctl_index = 8'h00;
        step();
        ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h20;
        step();
        chk("mid rom_we before", {63'd0, rom_we}, 64'd1);
        ioctl_wr = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("abort rom_we",     {63'd0, rom_we},     64'd0);
        chk("abort dsw",        dsw,                 64'd0);
        chk("abort sysmode",    {56'd0, sysmode},    64'd0);
        chk("abort rom_addr",   {39'd0, rom_addr},   64'd0);
        chk("abort core_reset", {63'd0, core_reset}, 64'd1);
        chk("abort dl_busy",    {63'd0, dl_busy},    64'd0);
        chk("abort checksum",   {56'd0, checksum},   64'd0);
        ioctl_download = 1'b0;
        step();
        reset_n = 1'b1;
        count_hold(n);
        chk("abort hold cycles", 64'(n), 64'd4800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
